// File: rtl/ph_pkg.sv
// ph_pkg: shared mode encoding, availability threshold helper and default FIFO sizes
package ph_pkg;
  typedef enum logic {PH_MODE_ONE = 1'b0, PH_MODE_TWO = 1'b1} ph_mode_e;
  localparam int PH_DEFAULT_DEPTH = 2;
  localparam int PH_DEFAULT_WIDTH = 8;
  function automatic int ph_threshold(input ph_mode_e mode);
    return (mode == PH_MODE_TWO) ? 2 : 1;
  endfunction
endpackage

// File: rtl/ph_fifo_ram_m.sv
// ph_fifo_ram_m: DEPTH x WIDTH register array, one sync write port (we/waddr/wdata), one async read port (raddr/rdata)
module ph_fifo_ram_m #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/ph_fifo_m.sv
// ph_fifo_m: host-to-parasite byte FIFO with 1-/2-byte mode thresholds.
// Ports: clk, rst (sync, active-high); wr_strobe/wr_data push; mode_two selects 2-byte mode;
// p2_select/p2_rdnw read access popping p2_data (zero latency); p2_data_available, p1_full, count status.
// Optional macro PH_FIFO_OVERRUN_EN adds sticky overrun output and err_clear input.
module ph_fifo_m
  import ph_pkg::*;
#(
  parameter int DEPTH = PH_DEFAULT_DEPTH,
  parameter int WIDTH = PH_DEFAULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_strobe,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   mode_two,
  input  logic                   p2_select,
  input  logic                   p2_rdnw,
  output logic [WIDTH-1:0]       p2_data,
  output logic                   p2_data_available,
  output logic                   p1_full,
`ifdef PH_FIFO_OVERRUN_EN
  input  logic                   err_clear,
  output logic                   overrun,
`endif
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          mode_two_q, mode_two_d;
  logic          flush, full, rd_req, push, pop;
`ifdef PH_FIFO_OVERRUN_EN
  logic          overrun_q, overrun_d;
`endif
  always_comb begin
    flush      = mode_two != mode_two_q;
    full       = count_q == CW'(DEPTH);
    rd_req     = p2_select & p2_rdnw;
    pop        = rd_req & (count_q != '0) & ~flush;
    // a simultaneous pop frees the head slot, so a push into a full FIFO still lands
    push       = wr_strobe & (~full | pop) & ~flush;
    count_d    = flush ? '0 : count_q + CW'(push) - CW'(pop);
    wptr_d     = flush ? '0 : wptr_q + AW'(push);
    rptr_d     = flush ? '0 : rptr_q + AW'(pop);
    mode_two_d = mode_two;
`ifdef PH_FIFO_OVERRUN_EN
    overrun_d  = (~flush & ((wr_strobe & full & ~pop) | (rd_req & (count_q == '0)))) |
                 (~err_clear & overrun_q);
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      mode_two_q <= 1'b0;
`ifdef PH_FIFO_OVERRUN_EN
      overrun_q  <= 1'b0;
`endif
    end else begin
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mode_two_q <= mode_two_d;
`ifdef PH_FIFO_OVERRUN_EN
      overrun_q  <= overrun_d;
`endif
    end
  end
  ph_fifo_ram_m #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wptr_q),
    .wdata (wr_data),
    .raddr (rptr_q),
    .rdata (p2_data)
  );
  assign count             = count_q;
  assign p2_data_available = count_q >= CW'(ph_threshold(ph_mode_e'(mode_two_q)));
  assign p1_full           = mode_two_q ? full : (count_q != '0);
`ifdef PH_FIFO_OVERRUN_EN
  assign overrun = overrun_q;
`endif
endmodule

// File: tb/tb_ph_fifo_m.sv
// tb_ph_fifo_m: directed plus randomized checks of ph_fifo_m against a queue-based reference model
module tb_ph_fifo_m;
  localparam int D = 2;
  logic       clk = 1'b0;
  logic       rst, wr_strobe, mode_two, p2_select, p2_rdnw, err_clear;
  logic [7:0] wr_data, p2_data;
  logic       p2_data_available, p1_full;
  logic [1:0] count;
`ifdef PH_FIFO_OVERRUN_EN
  logic       overrun;
`endif
  int unsigned vectors = 0, miscompares = 0;
  logic [7:0] q[$];
  logic       m_mode = 1'b0, m_ovr = 1'b0;

  ph_fifo_m #(.DEPTH(D), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .wr_strobe(wr_strobe), .wr_data(wr_data), .mode_two(mode_two),
    .p2_select(p2_select), .p2_rdnw(p2_rdnw), .p2_data(p2_data),
    .p2_data_available(p2_data_available), .p1_full(p1_full),
`ifdef PH_FIFO_OVERRUN_EN
    .err_clear(err_clear), .overrun(overrun),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("count", 32'(count), 32'(q.size()));
    chk("avail", 32'(p2_data_available), 32'(q.size() >= (m_mode ? 2 : 1)));
    chk("full", 32'(p1_full), 32'(m_mode ? (q.size() == D) : (q.size() >= 1)));
    if (q.size() != 0) chk("head", 32'(p2_data), 32'(q[0]));
`ifdef PH_FIFO_OVERRUN_EN
    chk("overrun", 32'(overrun), 32'(m_ovr));
`endif
  endtask

  task automatic step(input logic r, input logic ws, input logic [7:0] wd, input logic mt,
                      input logic rd, input logic ec);
    bit pop_ok, push_ok, set;
    rst = r; wr_strobe = ws; wr_data = wd; mode_two = mt;
    p2_select = rd; p2_rdnw = rd; err_clear = ec;
    check_model();
    @(posedge clk);
    if (r) begin
      q.delete(); m_mode = 1'b0; m_ovr = 1'b0;
    end else if (mt != m_mode) begin
      q.delete(); m_mode = mt; m_ovr = m_ovr & ~ec;
    end else begin
      pop_ok  = rd && q.size() > 0;
      push_ok = ws && (q.size() < D || pop_ok);
      set     = (ws && q.size() == D && !pop_ok) || (rd && q.size() == 0);
      if (pop_ok) void'(q.pop_front());
      if (push_ok) q.push_back(wd);
      m_ovr = set ? 1'b1 : (ec ? 1'b0 : m_ovr);
    end
    #1;
  endtask

  initial begin
    @(negedge clk);
    step(1, 0, 8'h00, 0, 0, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(p1_full), 0);
    step(0, 1, 8'hA5, 0, 0, 0);
    chk("t1_data", 32'(p2_data), 32'hA5);
    chk("t1_full", 32'(p1_full), 1);
    step(0, 0, 8'h00, 0, 1, 0);
    chk("t1_rd_count", 32'(count), 0);
    step(0, 0, 8'h00, 1, 0, 0);
    step(0, 1, 8'h11, 1, 0, 0);
    chk("t2_avail1", 32'(p2_data_available), 0);
    step(0, 1, 8'h22, 1, 0, 0);
    chk("t2_avail2", 32'(p2_data_available), 1);
    step(0, 1, 8'h33, 1, 0, 0);
    chk("t3_drop_count", 32'(count), 2);
    chk("t3_drop_head", 32'(p2_data), 32'h11);
`ifdef PH_FIFO_OVERRUN_EN
    chk("t3_overrun", 32'(overrun), 1);
`endif
    step(0, 0, 8'h00, 1, 0, 1);
    step(0, 1, 8'h44, 1, 1, 0);
    chk("t4_count", 32'(count), 2);
    step(0, 0, 8'h00, 1, 1, 0);
    chk("t4_order", 32'(p2_data), 32'h44);
    step(0, 0, 8'h00, 1, 1, 0);
    step(0, 0, 8'h00, 1, 1, 0);
    chk("t6_empty", 32'(count), 0);
`ifdef PH_FIFO_OVERRUN_EN
    chk("t6_overrun", 32'(overrun), 1);
`endif
    step(0, 1, 8'h5C, 1, 1, 1);
    chk("t4_pr_data", 32'(p2_data), 32'h5C);
    step(0, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'h66, 0, 0, 0);
    step(0, 1, 8'h77, 1, 0, 0);
    chk("t5_flush", 32'(count), 0);
    step(0, 1, 8'h88, 1, 0, 0);
    step(1, 1, 8'h99, 1, 0, 0);
    chk("t5_rst", 32'(count), 0);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, 8'($urandom),
           ($urandom_range(0, 29) == 0) ? ~m_mode : m_mode,
           $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    end
    check_model();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
